// File: rtl/bank_load_if.sv
// bank_load_if
//   Bundles the command channel, the beat stream and the load-mux drive
//   lines of bank_load_ctrl.
//   master : command/beat source and observer of the mux lines
//   slave  : the controller itself
//   Signals:
//     cmd_valid/cmd_ready, cmd_msm, cmd_bg_sel, cmd_base[11:0], cmd_len[11:0]
//     s_valid/s_ready, s_data[WIDTH_DATA_LOAD-1:0]
//     flag_msm, bg_sel, ntt_load_addr[9:0], ntt_load_en, ntt_load_wen,
//     msm_load_addr[11:0], msm_load_en, msm_load_wen,
//     data_load_in[WIDTH_DATA_LOAD-1:0], busy, done, err
interface bank_load_if #(
    parameter int WIDTH_DATA_LOAD = 512
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_msm;
    logic                       cmd_bg_sel;
    logic [11:0]                cmd_base;
    logic [11:0]                cmd_len;
    logic                       s_valid;
    logic                       s_ready;
    logic [WIDTH_DATA_LOAD-1:0] s_data;
    logic                       flag_msm;
    logic                       bg_sel;
    logic [9:0]                 ntt_load_addr;
    logic                       ntt_load_en;
    logic                       ntt_load_wen;
    logic [11:0]                msm_load_addr;
    logic                       msm_load_en;
    logic                       msm_load_wen;
    logic [WIDTH_DATA_LOAD-1:0] data_load_in;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport master (
        output cmd_valid, cmd_msm, cmd_bg_sel, cmd_base, cmd_len, s_valid, s_data,
        input  cmd_ready, s_ready, flag_msm, bg_sel, ntt_load_addr, ntt_load_en,
               ntt_load_wen, msm_load_addr, msm_load_en, msm_load_wen,
               data_load_in, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_msm, cmd_bg_sel, cmd_base, cmd_len, s_valid, s_data,
        output cmd_ready, s_ready, flag_msm, bg_sel, ntt_load_addr, ntt_load_en,
               ntt_load_wen, msm_load_addr, msm_load_en, msm_load_wen,
               data_load_in, busy, done, err
    );
endinterface

// File: rtl/bank_load_ctrl.sv
// bank_load_ctrl
//   Sequencer for the six-bank-group load mux of the NTT/MSM accelerator.
//   Takes one load command (mode, group select, base, beat count), streams
//   that many beats from a valid/ready source into the mux as registered
//   write strobes at base+idx, and pulses done when the command retires.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - bank_load_if.slave (command, beat stream, mux drive lines)
//   Build option:
//     BANK_LOAD_CTRL_RANGE_CHK_EN - reject commands whose base+len exceeds
//     the selected mode's depth (err and done pulse together, no strobes).
//     Undefined: no check, addresses wrap at port width, err stays 0.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready=1
//   RUN   | accepting beats, s_ready=1
//   DONE  | one-cycle retire (done=1), then IDLE
module bank_load_ctrl #(
    parameter int WIDTH_DATA_LOAD = 512,
    parameter int NTT_DEPTH       = 1024,
    parameter int MSM_DEPTH       = 2560
) (
    input  logic        clk,
    input  logic        rst,
    bank_load_if.slave  bus
);
    localparam int NTT_AW = $clog2(NTT_DEPTH);
    localparam int MSM_AW = $clog2(MSM_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       msm_q, msm_d;
    logic                       bg_q, bg_d;
    logic [11:0]                base_q, base_d;
    logic [11:0]                len_q, len_d;
    logic [11:0]                idx_q, idx_d;
    logic [WIDTH_DATA_LOAD-1:0] data_q, data_d;
    logic [NTT_AW-1:0]          ntt_addr_q, ntt_addr_d;
    logic                       ntt_en_q, ntt_en_d;
    logic [MSM_AW-1:0]          msm_addr_q, msm_addr_d;
    logic                       msm_en_q, msm_en_d;
    logic                       err_q, err_d;
    logic                       cmd_ready, s_ready;
    logic                       reject;
    logic [11:0]                addr_cur;

`ifdef BANK_LOAD_CTRL_RANGE_CHK_EN
    // 13-bit sum so base+len cannot wrap past the depth limit
    logic [12:0] end_beat;
    logic [12:0] depth;
    assign end_beat = {1'b0, bus.cmd_base} + {1'b0, bus.cmd_len};
    assign depth    = bus.cmd_msm ? 13'(MSM_DEPTH) : 13'(NTT_DEPTH);
    assign reject   = (end_beat > depth);
`else
    assign reject   = 1'b0;
`endif

    assign addr_cur = base_q + idx_q;

    always_comb begin
        state_d    = state_q;
        msm_d      = msm_q;
        bg_d       = bg_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        ntt_addr_d = ntt_addr_q;
        msm_addr_d = msm_addr_q;
        ntt_en_d   = 1'b0;
        msm_en_d   = 1'b0;
        err_d      = 1'b0;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    msm_d  = bus.cmd_msm;
                    bg_d   = bus.cmd_bg_sel;
                    base_d = bus.cmd_base;
                    len_d  = bus.cmd_len;
                    idx_d  = '0;
                    // the mode not being loaded parks its address at 0
                    if (bus.cmd_msm) ntt_addr_d = '0;
                    else             msm_addr_d = '0;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (bus.cmd_len == 12'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    data_d = bus.s_data;
                    if (msm_q) begin
                        msm_en_d   = 1'b1;
                        msm_addr_d = addr_cur[MSM_AW-1:0];
                    end else begin
                        ntt_en_d   = 1'b1;
                        ntt_addr_d = addr_cur[NTT_AW-1:0];
                    end
                    idx_d = idx_q + 12'd1;
                    if (idx_q == len_q - 12'd1) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msm_q      <= 1'b0;
            bg_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            ntt_addr_q <= '0;
            msm_addr_q <= '0;
            ntt_en_q   <= 1'b0;
            msm_en_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            msm_q      <= msm_d;
            bg_q       <= bg_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            ntt_addr_q <= ntt_addr_d;
            msm_addr_q <= msm_addr_d;
            ntt_en_q   <= ntt_en_d;
            msm_en_q   <= msm_en_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.s_ready       = s_ready;
    assign bus.flag_msm      = msm_q;
    assign bus.bg_sel        = bg_q;
    assign bus.ntt_load_addr = ntt_addr_q;
    assign bus.ntt_load_en   = ntt_en_q;
    assign bus.ntt_load_wen  = ntt_en_q;
    assign bus.msm_load_addr = msm_addr_q;
    assign bus.msm_load_en   = msm_en_q;
    assign bus.msm_load_wen  = msm_en_q;
    assign bus.data_load_in  = data_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.err           = err_q;
endmodule

// File: tb/tb_bank_load_ctrl.sv
module tb_bank_load_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    bank_load_if #(.WIDTH_DATA_LOAD(512)) bus ();

    bank_load_ctrl #(.WIDTH_DATA_LOAD(512), .NTT_DEPTH(1024), .MSM_DEPTH(2560)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] beat(input int k);
        logic [31:0] w;
        w = 32'hA5A50000 + k[31:0];
        return {16{w}};
    endfunction

    task automatic set_cmd(input logic m, input logic bg, input logic [11:0] base, input logic [11:0] len);
        bus.cmd_valid  = 1'b1;
        bus.cmd_msm    = m;
        bus.cmd_bg_sel = bg;
        bus.cmd_base   = base;
        bus.cmd_len    = len;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_msm = 1'b0; bus.cmd_bg_sel = 1'b0;
        bus.cmd_base = '0; bus.cmd_len = '0; bus.s_valid = 1'b0; bus.s_data = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_ntt_en", bus.ntt_load_en, 0);
        chk("rst_msm_en", bus.msm_load_en, 0);
        chk("rst_ntt_addr", bus.ntt_load_addr, 0);
        chk("rst_data", bus.data_load_in, 0);
        chk("rst_flag", {bus.flag_msm, bus.bg_sel, bus.busy, bus.done, bus.err}, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_s_ready", bus.s_ready, 0);

        // NTT, bg=1, base=10, len=4, continuous beats
        set_cmd(1'b0, 1'b1, 12'd10, 12'd4);
        bus.s_valid = 1'b1; bus.s_data = beat(0);
        tick;
        bus.cmd_valid = 1'b0;
        chk("t1_busy", bus.busy, 1);
        chk("t1_cmd_ready", bus.cmd_ready, 0);
        chk("t1_s_ready", bus.s_ready, 1);
        chk("t1_bg", bus.bg_sel, 1);
        chk("t1_no_strobe_yet", bus.ntt_load_en, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t1_en", {bus.ntt_load_en, bus.ntt_load_wen}, 2'b11);
            chk("t1_addr", bus.ntt_load_addr, 10 + i);
            chk("t1_data", bus.data_load_in, beat(i));
            chk("t1_msm_en", {bus.msm_load_en, bus.msm_load_wen}, 0);
            chk("t1_done", bus.done, (i == 3) ? 1 : 0);
            bus.s_data = beat(i + 1);
        end
        bus.s_valid = 1'b0;
        tick;
        chk("t1_idle_en", bus.ntt_load_en, 0);
        chk("t1_idle_done", bus.done, 0);
        chk("t1_bg_hold", bus.bg_sel, 1);
        chk("t1_addr_hold", bus.ntt_load_addr, 13);
        chk("t1_idle_ready", {bus.cmd_ready, bus.busy}, 2'b10);

        // MSM, base=2046, len=4, s_valid every other cycle
        set_cmd(1'b1, 1'b0, 12'd2046, 12'd4);
        tick;
        bus.cmd_valid = 1'b0;
        chk("t2_flag", bus.flag_msm, 1);
        chk("t2_bg", bus.bg_sel, 0);
        chk("t2_ntt_addr_parked", bus.ntt_load_addr, 0);
        for (int k = 0; k < 4; k++) begin
            bus.s_valid = 1'b1; bus.s_data = beat(10 + k);
            tick;
            bus.s_valid = 1'b0;
            chk("t2_en", {bus.msm_load_en, bus.msm_load_wen}, 2'b11);
            chk("t2_addr", bus.msm_load_addr, 2046 + k);
            chk("t2_data", bus.data_load_in, beat(10 + k));
            chk("t2_ntt_en", bus.ntt_load_en, 0);
            chk("t2_flag_run", bus.flag_msm, 1);
            chk("t2_done", bus.done, (k == 3) ? 1 : 0);
            if (k < 3) begin
                tick;
                chk("t2_gap_en", bus.msm_load_en, 0);
                chk("t2_gap_addr", bus.msm_load_addr, 2046 + k);
            end
        end
        // s_valid outside RUN must be ignored
        bus.s_valid = 1'b1; bus.s_data = beat(99);
        tick;
        chk("t2_done_ignore_en", bus.msm_load_en, 0);
        chk("t2_done_ignore_data", bus.data_load_in, beat(13));
        tick;
        chk("t2_idle_ignore_data", bus.data_load_in, beat(13));
        chk("t2_idle_s_ready", bus.s_ready, 0);
        chk("t2_flag_hold", bus.flag_msm, 1);
        bus.s_valid = 1'b0;

        // empty command
        set_cmd(1'b0, 1'b1, 12'd5, 12'd0);
        tick;
        bus.cmd_valid = 1'b0;
        chk("t3_done", {bus.done, bus.busy}, 2'b11);
        chk("t3_en", {bus.ntt_load_en, bus.msm_load_en}, 0);
        chk("t3_msm_addr_parked", bus.msm_load_addr, 0);
        chk("t3_flag", {bus.flag_msm, bus.bg_sel}, 2'b01);
        tick;
        chk("t3_idle", {bus.done, bus.busy, bus.cmd_ready}, 3'b001);

`ifdef BANK_LOAD_CTRL_RANGE_CHK_EN
        set_cmd(1'b1, 1'b0, 12'd2558, 12'd4);
        tick;
        bus.cmd_valid = 1'b0;
        chk("t4_err_done", {bus.err, bus.done}, 2'b11);
        chk("t4_flag", {bus.flag_msm, bus.bg_sel}, 2'b10);
        chk("t4_no_strobe", {bus.ntt_load_en, bus.msm_load_en}, 0);
        tick;
        chk("t4_idle", {bus.err, bus.done, bus.msm_load_en, bus.cmd_ready}, 4'b0001);
`else
        set_cmd(1'b0, 1'b0, 12'd1022, 12'd4);
        bus.s_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        chk("t4_err", bus.err, 0);
        for (int i = 0; i < 4; i++) begin
            bus.s_data = beat(20 + i);
            tick;
            chk("t4_en", bus.ntt_load_en, 1);
            chk("t4_addr", bus.ntt_load_addr, (i < 2) ? (1022 + i) : (i - 2));
            chk("t4_data", bus.data_load_in, beat(20 + i));
        end
        chk("t4_done", {bus.done, bus.err}, 2'b10);
        bus.s_valid = 1'b0;
        tick;
`endif

        // back-to-back with cmd_valid held
        set_cmd(1'b0, 1'b0, 12'd100, 12'd2);
        bus.s_valid = 1'b1; bus.s_data = beat(30);
        tick;
        bus.cmd_bg_sel = 1'b1; bus.cmd_base = 12'd200; bus.cmd_len = 12'd1;
        tick;
        chk("t5_b0_addr", bus.ntt_load_addr, 100);
        bus.s_data = beat(31);
        tick;
        chk("t5_b1_addr", bus.ntt_load_addr, 101);
        chk("t5_last_done", bus.done, 1);
        chk("t5_last_ready", bus.cmd_ready, 0);
        tick;
        chk("t5_n1_ready", bus.cmd_ready, 1);
        chk("t5_n1_bg", bus.bg_sel, 0);
        chk("t5_n1_en", bus.ntt_load_en, 0);
        tick;
        bus.cmd_valid = 1'b0;
        chk("t5_n2_bg", bus.bg_sel, 1);
        chk("t5_n2_busy", {bus.busy, bus.cmd_ready}, 2'b10);
        bus.s_data = beat(32);
        tick;
        chk("t5_c2_en", bus.ntt_load_en, 1);
        chk("t5_c2_addr", bus.ntt_load_addr, 200);
        chk("t5_c2_done", bus.done, 1);
        bus.s_valid = 1'b0;
        tick;

        // reset in the middle of an NTT command after 3 beats
        set_cmd(1'b0, 1'b1, 12'd0, 12'd8);
        bus.s_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.s_data = beat(40 + i);
            tick;
        end
        chk("t6_pre_addr", bus.ntt_load_addr, 2);
        chk("t6_pre_en", bus.ntt_load_en, 1);
        rst = 1'b1;
        #3;
        chk("t6_async_en", {bus.ntt_load_en, bus.msm_load_en}, 0);
        rst = 1'b0;
        tick;
        chk("t6_en", {bus.ntt_load_en, bus.ntt_load_wen, bus.msm_load_en}, 0);
        chk("t6_ready", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
        tick;
        chk("t6_en2", bus.ntt_load_en, 0);
        chk("t6_done2", bus.done, 0);
        chk("t6_addr", bus.ntt_load_addr, 0);
        bus.s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bank_load_ctrl.md
# bank_load_ctrl

Sequencer that drives the six-bank-group load mux of the NTT/MSM accelerator. It accepts one load command at a time: mode, bank-group select, base address and beat count. It then streams the matching number of data beats from a valid/ready source into the mux as registered write strobes with incrementing addresses, and pulses `done` when the command retires. It owns `flag_msm`, `bg_sel`, the NTT/MSM load address/enable/write-enable lines and `data_load_in` of the load mux.

## Interface
- `WIDTH_DATA_LOAD`, 512, data beat width
- `NTT_DEPTH`, 1024, NTT address space in beats
- `MSM_DEPTH`, 2560, MSM address space in beats (2048 + 384 + 128)

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can take a command
- `cmd_msm`  in  1  0 = NTT load, 1 = MSM load
- `cmd_bg_sel`  in  1  bank-group set select, forwarded to the mux
- `cmd_base`  in  12  first beat address (NTT uses [9:0])
- `cmd_len`  in  12  number of beats; 0 = empty command
- `s_valid`  in  1  data beat offered
- `s_ready`  out  1  controller accepts the beat
- `s_data`  in  WIDTH_DATA_LOAD  beat payload
- `flag_msm`  out  1  registered mode to the mux
- `bg_sel`  out  1  registered group select to the mux
- `ntt_load_addr`  out  10  NTT write address
- `ntt_load_en`, `ntt_load_wen`  out  1 each  NTT strobes
- `msm_load_addr`  out  12  MSM write address
- `msm_load_en`, `msm_load_wen`  out  1 each  MSM strobes
- `data_load_in`  out  WIDTH_DATA_LOAD  registered beat to the mux
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle retire pulse
- `err`  out  1  one-cycle reject pulse (only with the range check compiled in)

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `cmd_ready`=1, `s_ready`=0.
  - On `cmd_valid`, latch mode, group select, base and length, and clear beat index `idx`.
  - `flag_msm`/`bg_sel` update on the same edge.
  - Next state: len==0 → DONE; else → RUN.
- **RUN**
  - `cmd_ready`=0 and `s_ready`=1, both combinational from state.
  - Each handshake (`s_valid`&&`s_ready`) registers `data_load_in`=`s_data`, asserts en and wen of the active mode for one cycle, and sets address = base+idx.
  - NTT address is truncated to 10 bits; MSM address is 12 bits, modulo 4096.
  - `idx` increments on each handshake; a beat with idx==len-1 moves to DONE.
  - Cycles with no handshake: en=wen=0, address and data hold.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Inactive mode: en/wen always 0 and address held at 0.
- `flag_msm`/`bg_sel` hold after retirement until the next command is accepted.
- Reset values: all outputs 0, state IDLE, `cmd_ready`=1 after reset release.
- Reset mid-command abandons the command; no further strobes are issued.

## Timing
- Command accept → first possible beat handshake: 1 cycle (RUN is entered on the next edge).
- Beat handshake at edge N → en/wen/addr/data valid during cycle N+1 (1-cycle latency).
- Sustained throughput: 1 beat/cycle.
- Last beat handshake at N → strobe in N+1 and `done` in N+1.
- Earliest next command accept: N+2.
- Minimum command turnaround, len=L and continuous `s_valid`: L+2 cycles from accept to next `cmd_ready`.
- `s_data` is never captured outside RUN; `s_valid` in IDLE/DONE is ignored.

## Configuration
- `BANK_LOAD_CTRL_RANGE_CHK_EN` defined:
  - On accept, reject if base+len > depth for the selected mode (13-bit compare).
  - Reject behaviour: go IDLE→DONE with `err`=1 and `done`=1 in the same cycle.
  - A rejected command issues no strobes, and `flag_msm`/`bg_sel` still update.
- Undefined:
  - No check; addresses wrap modulo port width.
  - `err` tied to 0.

## Test plan
- Reset mid-RUN (NTT, len=8, after 3 beats) → all strobes 0 next cycle, `cmd_ready`=1, no `done`.
- NTT, bg_sel=1, base=10, len=4, continuous `s_valid` → `ntt_load_en`/`ntt_load_wen`=1 on four consecutive cycles at addr 10..13, data matches beats, `done` with last strobe, msm strobes 0.
- MSM, base=2046, len=4, `s_valid` toggling every other cycle → strobes at 2046, 2047, 2048, 2049 only on handshake+1 cycles, `flag_msm`=1 throughout.
- len=0 command → no strobes, `done` one cycle after accept, `busy` for 1 cycle.
- With the macro: MSM base=2558, len=4 → `err`=`done`=1, no strobes. Without the macro: NTT base=1022, len=4 → addresses 1022, 1023, 0, 1.
- Back-to-back commands with `cmd_valid` held → second accepted exactly 2 cycles after the first command's last handshake, `bg_sel` switches on that edge.
